// File: rtl/rgb_luma_pipe.sv
// Three-stage RGB-to-luma converter with programmable weights, bit-depth
// reduction (truncate / round / 4x4 ordered dither / invert) and valid/ready flow.

module rgb_luma_mul #(
  parameter int IN_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [IN_W-1:0] c,
  input  logic [7:0]      w,
  output logic [IN_W+7:0] p
);
  localparam int PW = IN_W + 8;

  always_ff @(posedge clk)
    if (rst)     p <= '0;
    else if (en) p <= PW'(c) * PW'(w);
endmodule

module rgb_luma_pipe #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       cfg_wr,
  input  logic [7:0]       cfg_wg,
  input  logic [7:0]       cfg_wb,
  input  logic [1:0]       cfg_mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_sof,
  input  logic             s_sol,
  input  logic [IN_W-1:0]  s_r,
  input  logic [IN_W-1:0]  s_g,
  input  logic [IN_W-1:0]  s_b,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_y
);
  localparam int D      = IN_W - OUT_W;
  localparam int STAGES = 2;
  localparam int PW     = IN_W + 8;
  localparam int SW     = IN_W + 10;
  localparam int YW     = IN_W + 5;
  localparam logic [IN_W-1:0]  LMAX = '1;
  localparam logic [OUT_W-1:0] YMAX = '1;

  // Per-pixel sideband that travels alongside the datapath.
  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] x;
    logic [1:0] y;
  } ctx_t;

  logic [STAGES:0]          vld_pipe;
  logic                     adv;
  logic [1:0]               x_cnt, y_cnt, px, py;
  ctx_t                     ctx_in, ctx1, ctx2;
  logic [2:0][IN_W-1:0]     chan;
  logic [2:0][7:0]          wgt;
  logic [2:0][PW-1:0]       prod;
  logic [SW-1:0]            sum, lwide;
  logic [IN_W-1:0]          luma, luma2;
  logic [YW-1:0]            ext, yv;
  logic [3:0]               bt;
  logic [OUT_W-1:0]         y_nxt;

  assign adv     = !vld_pipe[STAGES] || m_ready;
  assign s_ready = adv && !rst;
  assign m_valid = vld_pipe[STAGES];

  // Position of the incoming pixel; sof wins over sol.
  always_comb begin
    px = x_cnt + 2'd1;
    py = y_cnt;
    if (s_sof) begin
      px = 2'd0;
      py = 2'd0;
    end else if (s_sol) begin
      px = 2'd0;
      py = y_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk)
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (s_valid && s_ready) begin
      x_cnt <= px;
      y_cnt <= py;
    end

  assign chan   = {s_r, s_g, s_b};
  assign wgt    = {cfg_wr, cfg_wg, cfg_wb};
  assign ctx_in = '{mode: cfg_mode, x: px, y: py};

  generate
    for (genvar i = 0; i < 3; i++) begin : g_lane
      rgb_luma_mul #(.IN_W(IN_W)) u_mul (
        .clk (clk),
        .rst (rst),
        .en  (adv),
        .c   (chan[i]),
        .w   (wgt[i]),
        .p   (prod[i])
      );
    end
  endgenerate

  always_comb begin
    sum   = SW'(prod[0]) + SW'(prod[1]) + SW'(prod[2]);
    lwide = sum >> 8;
    luma  = (lwide > SW'(LMAX)) ? LMAX : lwide[IN_W-1:0];
  end

  function automatic logic [3:0] bayer(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'd0:  return 4'd0;   4'd1:  return 4'd8;   4'd2:  return 4'd2;   4'd3:  return 4'd10;
      4'd4:  return 4'd12;  4'd5:  return 4'd4;   4'd6:  return 4'd14;  4'd7:  return 4'd6;
      4'd8:  return 4'd3;   4'd9:  return 4'd11;  4'd10: return 4'd1;   4'd11: return 4'd9;
      4'd12: return 4'd15;  4'd13: return 4'd7;   4'd14: return 4'd13;  default: return 4'd5;
    endcase
  endfunction

  // Final quantiser; the dither offset is the threshold scaled to the dropped bits.
  always_comb begin
    bt  = bayer(ctx2.y, ctx2.x);
    ext = YW'(luma2);
    case (ctx2.mode)
      2'd1:    yv = (ext + (YW'(1) << (D - 1))) >> D;
      2'd2:    yv = (ext + ((YW'(bt) << D) >> 4)) >> D;
      default: yv = ext >> D;
    endcase
    y_nxt = (yv > YW'(YMAX)) ? YMAX : yv[OUT_W-1:0];
    if (ctx2.mode == 2'd3) y_nxt = ~y_nxt;
  end

  always_ff @(posedge clk)
    if (rst) begin
      vld_pipe <= '0;
      ctx1     <= '0;
      ctx2     <= '0;
      luma2    <= '0;
      m_y      <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], s_valid};
      ctx1     <= ctx_in;
      ctx2     <= ctx1;
      luma2    <= luma;
      if (vld_pipe[STAGES-1]) m_y <= y_nxt;
    end
endmodule

// File: tb/tb_rgb_luma_pipe.sv
// Scoreboard bench for rgb_luma_pipe: driver pushes expected luma, monitor pops on handshake.

module tb_rgb_luma_pipe;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_wr, cfg_wg, cfg_wb;
  logic [1:0] cfg_mode;
  logic       s_valid, s_ready, s_sof, s_sol;
  logic [5:0] s_r, s_g, s_b;
  logic       m_valid, m_ready;
  logic [3:0] m_y;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int mon_e;

  rgb_luma_pipe #(.IN_W(6), .OUT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_wr   (cfg_wr),
    .cfg_wg   (cfg_wg),
    .cfg_wb   (cfg_wb),
    .cfg_mode (cfg_mode),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_sof    (s_sof),
    .s_sol    (s_sol),
    .s_r      (s_r),
    .s_g      (s_g),
    .s_b      (s_b),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_y      (m_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int wr, input int wg, input int wb, input int mode);
    cfg_wr   = wr[7:0];
    cfg_wg   = wg[7:0];
    cfg_wb   = wb[7:0];
    cfg_mode = mode[1:0];
  endtask

  // Called at posedge+1; returns at posedge+1 after the pixel is taken.
  task automatic send(input int r, input int g, input int b, input bit sof, input bit sol,
                      input bit track, input int exp);
    bit taken = 1'b0;
    s_r = r[5:0]; s_g = g[5:0]; s_b = b[5:0];
    s_sof = sof; s_sol = sol; s_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_ready) begin
        if (track) exp_q.push_back(exp);
        taken = 1'b1;
        break;
      end
    end
    if (!taken) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0; s_sol = 1'b0;
  endtask

  task automatic drain();
    bit empty = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        empty = 1'b1;
        break;
      end
    end
    if (!empty) chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk)
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected got=%0d want=none", m_y);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_y", int'(m_y), mon_e);
      end
    end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_sol = 1'b0;
    s_r = '0; s_g = '0; s_b = '0; m_ready = 1'b1;
    set_cfg(64, 128, 64, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_y", m_y, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Legacy truncate, with a latency check on an empty pipe.
    send(40, 20, 8, 1'b1, 1'b0, 1'b1, 5);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (m_valid) begin
        lat = k;
        break;
      end
    end
    chk("latency", lat, 3);
    @(posedge clk); #1;
    send(63, 63, 63, 1'b0, 1'b0, 1'b1, 15);
    set_cfg(64, 128, 64, 3);
    send(40, 20, 8, 1'b0, 1'b0, 1'b1, 10);

    // Rounding with saturation
    set_cfg(64, 128, 64, 1);
    send(40, 20, 8, 1'b0, 1'b0, 1'b1, 6);
    send(63, 63, 63, 1'b0, 1'b0, 1'b1, 15);

    // Ordered dither across frame/line starts
    set_cfg(64, 128, 64, 2);
    send(40, 20, 8, 1'b1, 1'b0, 1'b1, 5);
    send(40, 20, 8, 1'b0, 1'b0, 1'b1, 6);
    send(40, 20, 8, 1'b0, 1'b0, 1'b1, 5);
    send(40, 20, 8, 1'b0, 1'b0, 1'b1, 6);
    send(40, 20, 8, 1'b0, 1'b1, 1'b1, 6);
    send(40, 20, 8, 1'b0, 1'b0, 1'b1, 5);
    send(40, 20, 8, 1'b0, 1'b0, 1'b1, 6);
    send(40, 20, 8, 1'b0, 1'b0, 1'b1, 5);
    send(40, 20, 8, 1'b1, 1'b0, 1'b1, 5);
    send(40, 20, 8, 1'b0, 1'b0, 1'b1, 6);

    // Weight overflow clamps L
    set_cfg(255, 255, 255, 0);
    send(63, 63, 63, 1'b0, 1'b0, 1'b1, 15);
    set_cfg(255, 255, 255, 3);
    send(63, 63, 63, 1'b0, 1'b0, 1'b1, 0);
    drain();

    // Backpressure: stall the sink while the pipe is full
    set_cfg(64, 128, 64, 0);
    fork
      begin
        for (int v = 1; v <= 6; v++)
          send(4 * v, 4 * v, 4 * v, 1'b0, 1'b0, 1'b1, v);
      end
      begin
        bit seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (m_valid) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) chk("bp_first_out", 0, 1);
        @(posedge clk); #1;
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_m_valid", m_valid, 1);
          chk("bp_s_ready", s_ready, 0);
          chk("bp_m_y_hold", m_y, (exp_q.size() > 0) ? exp_q[0] : -1);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join
    drain();

    // Reset with the pipe full and the sink stalled
    set_cfg(64, 128, 64, 2);
    m_ready = 1'b0;
    send(40, 20, 4, 1'b1, 1'b0, 1'b0, 0);
    send(40, 20, 4, 1'b0, 1'b1, 1'b0, 0);
    send(40, 20, 4, 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_s_ready", s_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_m_y", m_y, 0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    // L=21: x=1,y=0 gives offset 2 -> 5; stale counters would give 6.
    send(40, 20, 4, 1'b0, 1'b0, 1'b1, 5);
    send(40, 20, 4, 1'b0, 1'b0, 1'b1, 5);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
